// File: rtl/inv_sbox_pkg.sv
// inv_sbox_pkg: shared types and sizing for the inverse S-box block.
//   state_e   - load/lookup/error controller states
//   DEPTH     - table depth for the default 8-bit symbol width
//   depth_of  - table depth for an arbitrary symbol width
package inv_sbox_pkg;

  localparam int BIT_WIDTH_DFLT = 8;
  localparam int DEPTH          = 2 ** BIT_WIDTH_DFLT;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  function automatic int depth_of(input int bw);
    return 2 ** bw;
  endfunction

endpackage

// File: rtl/inv_sbox_ram.sv
// inv_sbox_ram: DEPTH x DW inverse table storage.
//   clk, reset_n       - clock, synchronous active-low reset (read register only)
//   we_i/waddr_i/wdata_i - synchronous write port used while loading
//   re_i/raddr_i       - synchronous read port used for lookups
//   rdata_o            - registered read data; holds while re_i is low
module inv_sbox_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Table contents are never reset: a complete load overwrites every entry.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inv_sbox.sv
// inv_sbox: builds S^-1 from a streamed forward S-box, then substitutes
// ciphertext symbols back to plaintext with one cycle of latency.
//   clk, reset_n        - clock, synchronous active-low reset
//   load_tvalid, V_in   - forward table entry S[idx], idx counted internally
//   reload              - drop current table, restart loading at idx 0
//   tvalid, C_in        - ciphertext symbol to invert (honoured only when ready)
//   valid, P_out        - recovered symbol S^-1[C_in], one cycle after tvalid
//   ready               - full table loaded and verified to be a permutation
//   error               - a value repeated during the load (held until reload)
module inv_sbox
  import inv_sbox_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_tvalid,
  input  logic [BIT_WIDTH-1:0] V_in,
  input  logic                 reload,
  input  logic                 tvalid,
  input  logic [BIT_WIDTH-1:0] C_in,
  output logic                 valid,
  output logic [BIT_WIDTH-1:0] P_out,
  output logic                 ready,
  output logic                 error
);

  localparam int NENT = depth_of(BIT_WIDTH);
  // idx carries one spare bit so the last-entry compare never aliases a wrap.
  localparam logic [BIT_WIDTH:0] IDX_LAST = (BIT_WIDTH+1)'(NENT - 1);

  state_e               state_q, state_d;
  logic [BIT_WIDTH:0]   idx_q, idx_d;
  logic [NENT-1:0]      seen_q, seen_d;
  logic                 valid_q, valid_d;
  logic                 ram_we, ram_re;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seen_d  = seen_q;
    ram_we  = 1'b0;
    if (reload) begin
      // reload beats any concurrent load entry or lookup
      state_d = ST_LOAD;
      idx_d   = '0;
      seen_d  = '0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (load_tvalid) begin
            ram_we         = 1'b1;
            seen_d[V_in]   = 1'b1;
            idx_d          = idx_q + 1'b1;
            if (seen_q[V_in]) begin
              state_d = ST_ERROR;
            end else if (idx_q == IDX_LAST) begin
              state_d = ST_READY;
              idx_d   = '0;
            end
          end
        end
        ST_READY: ;
        ST_ERROR: ;
        default:  state_d = ST_LOAD;
      endcase
    end
  end

  // A lookup in the final READY cycle still completes; one with reload does not.
  assign ram_re  = tvalid && (state_q == ST_READY) && !reload;
  assign valid_d = ram_re;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      seen_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seen_q  <= seen_d;
      valid_q <= valid_d;
    end
  end

  inv_sbox_ram #(
    .AW (BIT_WIDTH),
    .DW (BIT_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (ram_we),
    .waddr_i (V_in),
    .wdata_i (idx_q[BIT_WIDTH-1:0]),
    .re_i    (ram_re),
    .raddr_i (C_in),
    .rdata_o (P_out)
  );

  assign valid = valid_q;
  assign ready = (state_q == ST_READY);
  assign error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_inv_sbox.sv
module tb_inv_sbox;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_tvalid = 1'b0;
  logic       reload = 1'b0;
  logic       tvalid = 1'b0;
  logic [7:0] V_in = 8'h00;
  logic [7:0] C_in = 8'h00;
  logic       valid, ready, error;
  logic [7:0] P_out;

  inv_sbox #(.BIT_WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_tvalid (load_tvalid),
    .V_in        (V_in),
    .reload      (reload),
    .tvalid      (tvalid),
    .C_in        (C_in),
    .valid       (valid),
    .P_out       (P_out),
    .ready       (ready),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;

  // Reference model: table contents as a mapping value -> position, plus
  // the set of values seen so far in the current load.
  int         m_st = 0;          // 0 loading, 1 ready, 2 error
  int         m_idx = 0;
  bit         m_seen[256];
  logic [7:0] m_inv[256];
  bit         exp_ready = 1'b0;
  bit         exp_error = 1'b0;
  logic [7:0] hold = 8'h00;
  logic [7:0] tbl[256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances by the same rules the block obeys.
  task automatic step(input bit lt, input logic [7:0] v, input bit rl,
                      input bit tv, input logic [7:0] c, input bit rst = 1'b0);
    reset_n = !rst; load_tvalid = lt; V_in = v; reload = rl; tvalid = tv; C_in = c;
    if (rst) begin
      m_st = 0; m_idx = 0;
      foreach (m_seen[i]) m_seen[i] = 1'b0;
      sbq.delete();
    end else begin
      if (tv && m_st == 1 && !rl) sbq.push_back('{m_inv[c], cyc + 1});
      if (rl) begin
        m_st = 0; m_idx = 0;
        foreach (m_seen[i]) m_seen[i] = 1'b0;
      end else if (m_st == 0 && lt) begin
        m_inv[v] = 8'(m_idx);
        if (m_seen[v]) m_st = 2;
        else if (m_idx == 255) begin m_st = 1; m_idx = 0; end
        else m_idx++;
        m_seen[v] = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    exp_ready = (m_st == 1);
    exp_error = (m_st == 2);
    if (rst) hold = 8'h00;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic load_tbl(input int n);
    for (int i = 0; i < n; i++) step(1'b1, tbl[i], 1'b0, 1'b0, 8'h00);
  endtask

  task automatic make_perm();
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [7:0] t;
      j = $urandom_range(i, 0);
      t = tbl[i]; tbl[i] = tbl[j]; tbl[j] = t;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 32'(valid), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("p_out", 32'(P_out), 32'(e.d));
          chk("latency", 32'(cyc), 32'(e.cyc));
          hold = e.d;
        end
      end else begin
        if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
          chk("missing_valid", 32'(valid), 32'd1);
          void'(sbq.pop_front());
        end
        chk("p_out_hold", 32'(P_out), 32'(hold));
      end
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("error", 32'(error), 32'(exp_error));
    end
  end

  initial begin
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_p_out", 32'(P_out), 32'd0);
    idle(2);

    // identity table, three spot lookups with gaps
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
    load_tbl(255);
    chk("not_ready_before_last", 32'(ready), 32'd0);
    step(1'b1, tbl[255], 1'b0, 1'b0, 8'h00);
    chk("ready_after_identity", 32'(ready), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00); idle(1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h7F); idle(1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF); idle(2);

    // rotate-by-one table, back-to-back stream of every symbol
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) tbl[i] = 8'((i + 1) % 256);
    load_tbl(256);
    for (int c = 0; c < 256; c++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'(c));
    idle(2);

    // duplicate at idx 10 (same value as idx 3), later lookups are dropped
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
    tbl[3] = 8'h42; tbl[10] = 8'h42;
    load_tbl(10);
    chk("no_error_before_dup", 32'(error), 32'd0);
    step(1'b1, tbl[10], 1'b0, 1'b0, 8'h00);
    chk("error_after_dup", 32'(error), 32'd1);
    for (int i = 11; i < 256; i++) step(1'b1, tbl[i], 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'(i * 40));
    idle(1);
    chk("error_sticky", 32'(error), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("error_cleared", 32'(error), 32'd0);
    make_perm();
    load_tbl(256);
    chk("ready_after_recover", 32'(ready), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom));

    // lookup attempted mid-load is dropped, load still completes
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    make_perm();
    for (int i = 0; i < 256; i++)
      step(1'b1, tbl[i], 1'b0, (i == 100), 8'h12);
    chk("ready_after_midload_lookup", 32'(ready), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h12);

    // reset at idx 200, then a fresh permutation and random lookups
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    make_perm();
    load_tbl(200);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    make_perm();
    load_tbl(255);
    chk("not_ready_after_reset_255", 32'(ready), 32'd0);
    step(1'b1, tbl[255], 1'b0, 1'b0, 8'h00);
    for (int n = 0; n < 1000; ) begin
      bit tv;
      tv = ($urandom_range(3, 0) != 0);
      step(1'b0, 8'h00, 1'b0, tv, 8'($urandom));
      if (tv) n++;
    end
    idle(1);

    // last-cycle lookup completes; reload with tvalid yields nothing
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h05);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h06);
    chk("ready_drop_on_reload", 32'(ready), 32'd0);
    idle(1);
    chk("no_valid_after_reload_tvalid", 32'(valid), 32'd0);

    // reload together with an entry discards it and restarts at idx 0
    make_perm();
    load_tbl(50);
    step(1'b1, 8'hAA, 1'b1, 1'b0, 8'h00);
    load_tbl(256);
    chk("ready_after_reload_entry", 32'(ready), 32'd1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom));
    idle(3);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inv_sbox.md
# inv_sbox

Inverse S-box for the decryption path of the chaos-based image cipher. It receives the S-box stream from `sbox_generator`: one `V_out` byte per `valid`, 2^BIT_WIDTH entries in forward-index order. It builds the inverse permutation table from that stream. It then substitutes ciphertext bytes back to plaintext, one byte per `tvalid`, with fixed latency. It also checks that the loaded table is a true permutation.

## Interface
Parameters:
- `BIT_WIDTH`, 8 — symbol width; the table has DEPTH = 2^BIT_WIDTH entries.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `reset_n`  in  1  — synchronous, active-low reset.
- `load_tvalid`  in  1  — one forward S-box entry is present on `V_in` this cycle.
- `V_in`  in  BIT_WIDTH  — forward S-box value S[idx], where idx is the internal load counter.
- `reload`  in  1  — single-cycle pulse; discard the current table and restart loading.
- `tvalid`  in  1  — ciphertext byte is present on `C_in`.
- `C_in`  in  BIT_WIDTH  — ciphertext byte.
- `valid`  out  1  — `P_out` is valid this cycle.
- `P_out`  out  BIT_WIDTH  — recovered byte, equal to S^-1[C_in].
- `ready`  out  1  — table fully loaded and verified as a permutation.
- `error`  out  1  — sticky flag: a duplicate value appeared during the load.

## Operation
- States:
  - LOAD (entered on reset).
  - READY.
  - ERROR.
- LOAD:
  - On `load_tvalid`: write `inv[V_in] <= idx` and set `seen[V_in]`.
  - If `seen[V_in]` was already 1, set `error` and go to ERROR after this write.
  - Increment `idx`.
  - When the entry with idx = DEPTH-1 is accepted without a duplicate, go to READY and clear `idx` to 0.
- READY:
  - On `tvalid`: read `inv[C_in]`.
  - Next cycle: `valid` = 1 and `P_out` = read data.
  - `load_tvalid` is ignored.
- ERROR:
  - `tvalid` and `load_tvalid` are ignored.
  - `valid` = 0 and `error` = 1 until `reload` or reset.
- `reload` (any state):
  - Next state is LOAD.
  - `idx` is cleared, the `seen` bitmap is cleared in one cycle, and `ready` and `error` are cleared.
  - The `inv` contents are not cleared; they are fully overwritten by the next load.
- `tvalid` while not in READY: dropped, no `valid` response.
- Arithmetic:
  - `idx` is BIT_WIDTH+1 bits internally; it never wraps silently.
  - Completion is detected at idx = DEPTH-1 while `load_tvalid` is high.

## Timing
- Reset values: `valid` 0, `P_out` 0, `ready` 0, `error` 0; state LOAD; `idx` 0; `seen` all 0.
- Load:
  - One entry per cycle, back-to-back allowed.
  - `ready` rises the cycle after the final entry is accepted.
  - Minimum load time is DEPTH cycles.
- Lookup:
  - Latency is 1 cycle from `tvalid` to `valid`.
  - Full throughput, one byte per cycle.
  - `valid` is a registered copy of (`tvalid` and state == READY).
- `P_out` holds its last value when `valid` = 0.
- `error` rises the cycle after the duplicate entry is accepted.
- Simultaneous events:
  - `reload` together with `tvalid` in READY: `reload` wins; no `valid` the next cycle.
  - `reload` together with `load_tvalid`: the entry is discarded and loading restarts at idx 0.
  - A lookup issued in the last READY cycle before `reload` still completes, with `valid` high the following cycle.
- Reset mid-load: returns to LOAD with `idx` 0 and `seen` cleared. Partial table data is discarded logically.

## Structure
- Package `inv_sbox_pkg` holds:
  - the state enum (LOAD, READY, ERROR);
  - the localparam DEPTH = 2**BIT_WIDTH.
- Sub-module `inv_sbox_ram`:
  - DEPTH × BIT_WIDTH memory;
  - one synchronous write port (load) and one synchronous read port (lookup);
  - registered read data drives `P_out`.
- The `seen` bitmap, load counter and FSM live in the top of `inv_sbox`.

## Test plan
- Identity load (S[i] = i for 0..255), then lookup 0x00, 0x7F, 0xFF -> `ready` = 1 after 256 cycles; `P_out` = 0x00, 0x7F, 0xFF, each 1 cycle after `tvalid`.
- Load S[i] = (i+1) mod 256, then stream `C_in` = 0x00..0xFF back-to-back -> `P_out` = 0xFF, 0x00, …, 0xFE with `valid` continuous; `error` stays 0.
- Load with S[10] = S[3] = 0x42 -> `error` = 1 the cycle after idx 10 is accepted; `ready` stays 0; later `tvalid` produces no `valid`. `reload` followed by a valid table -> `ready` = 1 and `error` = 0.
- `tvalid` with `C_in` = 0x12 at idx = 100 during load -> no `valid`; load completes normally.
- `reset_n` = 0 at idx = 200, then a full reload with a random permutation -> `ready` only after 256 new entries; lookups match a software inverse for 1000 random bytes.
- In READY: `reload` and `tvalid` asserted in the same cycle -> no `valid` next cycle; state LOAD; `ready` = 0.
